stack_memory_stage: RTL

Memory-access stage of the 16-bit pipelined processor, sitting between the execute/memory pipeline buffer and the memory/write-back buffer. It owns the data RAM and the stack pointer, and performs loads, stores, push/pop, and two-word PC push/pop for call/return. It produces the write-back data word and a restored PC. It stalls upstream for one cycle when a PC transfer needs a second RAM access.

---
 rtl/mem_stage_pkg.sv | 8 +
 rtl/data_ram.sv | 18 +
 rtl/stack_memory_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the memory-access stage.
package mem_stage_pkg;
  typedef enum logic {IDLE, PC_HI} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_PUSH_PC, OP_POP_PC, OP_PUSH, OP_POP, OP_STORE, OP_LOAD} op_t;
  function automatic int sp_reset_of(input int aw);
    return (1 << aw) - 1;
  endfunction
endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous RAM with registered read data.
module data_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // a write cycle also reads, so read-during-write yields the old word
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/stack_memory_stage.sv
// stack_memory_stage: data RAM access, stack pointer and two-word PC push/pop.
module stack_memory_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              push,
  input  logic              pop,
  input  logic              push_pc,
  input  logic              pop_pc,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] write_data,
  input  logic [31:0]       pc_in,
  output logic [DATA_W-1:0] data_out,
  output logic [31:0]       pc_out,
  output logic              pc_valid,
  output logic              stall,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_fault
);
  localparam logic [ADDR_W-1:0] SP_RESET = ADDR_W'(sp_reset_of(ADDR_W));
  state_t state, state_next;
  op_t op;
  logic ok_push, ok_pop, ok_push_pc, ok_pop_pc, go_pc, fault_set, wr_stack, rd_stack;
  logic ram_we, pc_push_q, pend, sel_q;
  logic [ADDR_W-1:0] ram_addr, sp_next, sp_inc, sp_dec;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, alu_q;
  logic [15:0] pc_hi_in, pc_hi_r;
  logic [31:0] pc_q;
  logic unused_addr;
  assign unused_addr = ^addr[DATA_W-1:ADDR_W];
  always_comb begin
    op = state == PC_HI ? OP_NONE : push_pc ? OP_PUSH_PC : pop_pc ? OP_POP_PC :
         push ? OP_PUSH : pop ? OP_POP : mem_write ? OP_STORE : mem_read ? OP_LOAD : OP_NONE;
    sp_inc = sp + ADDR_W'(1);
    sp_dec = sp - ADDR_W'(1);
    ok_push = sp != '0;
    ok_pop = sp != SP_RESET;
    ok_push_pc = sp >= ADDR_W'(2);
    ok_pop_pc = sp <= SP_RESET - ADDR_W'(2);
    go_pc = (op == OP_PUSH_PC && ok_push_pc) || (op == OP_POP_PC && ok_pop_pc);
    fault_set = (op == OP_PUSH && !ok_push) || (op == OP_POP && !ok_pop) ||
                (op == OP_PUSH_PC && !ok_push_pc) || (op == OP_POP_PC && !ok_pop_pc);
    wr_stack = (state == PC_HI && pc_push_q) || (op == OP_PUSH && ok_push) || (op == OP_PUSH_PC && ok_push_pc);
    rd_stack = (state == PC_HI && !pc_push_q) || (op == OP_POP && ok_pop) || (op == OP_POP_PC && ok_pop_pc);
    ram_we = wr_stack || op == OP_STORE;
    ram_addr = wr_stack ? sp : rd_stack ? sp_inc : addr[ADDR_W-1:0];
    ram_wdata = state == PC_HI ? DATA_W'(pc_hi_in) : op == OP_PUSH_PC ? DATA_W'(pc_in[15:0]) : write_data;
    sp_next = wr_stack ? sp_dec : rd_stack ? sp_inc : sp;
    state_next = go_pc ? PC_HI : IDLE;
    stall = state == PC_HI;
    pc_valid = pend;
    // the low PC word lands in the RAM read register only in the cycle after B
    pc_out = pend ? {pc_hi_r, ram_rdata[15:0]} : pc_q;
    data_out = sel_q ? ram_rdata : alu_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sp <= SP_RESET;
      stack_fault <= 1'b0;
      pc_push_q <= 1'b0;
      pc_hi_in <= '0;
      pc_hi_r <= '0;
      pend <= 1'b0;
      pc_q <= '0;
      sel_q <= 1'b0;
      alu_q <= '0;
    end else begin
      state <= state_next;
      sp <= sp_next;
      stack_fault <= stack_fault | fault_set;
      if (go_pc) begin
        pc_push_q <= op == OP_PUSH_PC;
        pc_hi_in <= pc_in[31:16];
      end
      if (state == PC_HI && !pc_push_q) pc_hi_r <= ram_rdata[15:0];
      pend <= state == PC_HI && !pc_push_q;
      if (pend) pc_q <= {pc_hi_r, ram_rdata[15:0]};
      sel_q <= mem_to_reg && (op == OP_LOAD || (op == OP_POP && ok_pop));
      alu_q <= alu_data;
    end
  end
  data_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk(clk), .we(ram_we), .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
endmodule
